// File: rtl/packet_forwarder_pkg.sv
// Shared types for the packet_ram read-out path: FSM states, FIFO entry layout, slot helper.
// Data width of the FIFO entry is fixed here and must match the forwarder's DATA_WIDTH.
package bpf_fwd_pkg;

  localparam int FWD_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH     = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fwd_state_e;

  typedef struct packed {
    logic [FWD_DATA_WIDTH-1:0] data;
    logic                      last;
  } fwd_entry_t;

  // Slots are numbered 0..FIFO_DEPTH-1, so pointers wrap at a non-power-of-two.
  function automatic logic [1:0] next_slot(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/packet_forwarder_if.sv
// AXI-Stream style word channel between the forwarder (master) and the downstream consumer (slave).
interface packet_forwarder_if
  import bpf_fwd_pkg::*;
#(
  parameter int DATA_WIDTH = FWD_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/packet_forwarder_fifo.sv
// 3-entry FIFO absorbing the RAM read latency; latency 1 cycle push-to-head.
// No internal backpressure: the producer's credit rule guarantees a free slot on every push.
module fwd_fifo
  import bpf_fwd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  fwd_entry_t push_dat_i,
  input  logic       pop_i,
  output fwd_entry_t head_dat_o,
  output logic [1:0] count_o
);

  fwd_entry_t mem_q [FIFO_DEPTH];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= next_slot(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_slot(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/packet_forwarder.sv
// Streams packet_ram words 0..last_idx out as AXI-Stream; first beat valid 2 cycles after the first read.
// Reads are throttled by FIFO occupancy plus the in-flight read, so tready stalls never overflow the FIFO.
module packet_forwarder
  import bpf_fwd_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = FWD_DATA_WIDTH
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fwd_start,
  input  logic [31:0]             pkt_len,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_rd_en,
  input  logic [2*DATA_WIDTH-1:0] ram_do,
  packet_forwarder_if.master      m_axis,
  output logic                    fwd_done,
  output logic                    busy
);

  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = '1;

  fwd_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  credit_ok;
  logic                  axis_vld;
  logic                  axis_pop;
  logic [1:0]            fifo_count;
  fwd_entry_t            push_dat;
  fwd_entry_t            head_dat;
  logic                  unused_ram_lo;

  // Only registered occupancy feeds the credit check, keeping tready off the read path.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    last_idx_d  = last_idx_q;
    addr_hold_d = addr_hold_q;
    ram_rd_en   = 1'b0;
    fwd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fwd_start) begin
          state_d    = RUN;
          rd_ptr_d   = '0;
          last_idx_d = (pkt_len > 32'(MAX_IDX)) ? MAX_IDX : pkt_len[ADDR_WIDTH-1:0];
        end
      end
      RUN: begin
        if (credit_ok) begin
          ram_rd_en   = 1'b1;
          addr_hold_d = rd_ptr_q;
          if (rd_ptr_q == last_idx_q) begin
            state_d = DRAIN;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (axis_pop && head_dat.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        fwd_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rd_ptr_q        <= '0;
      last_idx_q      <= '0;
      addr_hold_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      last_idx_q      <= last_idx_d;
      addr_hold_q     <= addr_hold_d;
      inflight_q      <= ram_rd_en;
      inflight_last_q <= ram_rd_en && (rd_ptr_q == last_idx_q);
    end
  end

  // Address is held between reads so packet_ram sees a quiet bus when idle or throttled.
  assign ram_addr = ram_rd_en ? rd_ptr_q : addr_hold_q;
  assign busy     = (state_q != IDLE);

  assign push_dat      = '{data: ram_do[2*DATA_WIDTH-1:DATA_WIDTH], last: inflight_last_q};
  assign unused_ram_lo = ^ram_do[DATA_WIDTH-1:0];

  fwd_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_dat_i (push_dat),
    .pop_i      (axis_pop),
    .head_dat_o (head_dat),
    .count_o    (fifo_count)
  );

  assign axis_vld      = (fifo_count != 2'd0);
  assign axis_pop      = axis_vld && m_axis.tready;
  assign m_axis.tvalid = axis_vld;
  assign m_axis.tdata  = head_dat.data;
  assign m_axis.tlast  = head_dat.last;

endmodule
